// File: rtl/regfile.sv
// 32 x 32-bit register file: two combinational read ports, one rising-edge write
// port, asynchronous active-low clear. r0 is not stored and always reads zero.
module regfile (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [4:0]  Ra,
  input  logic [4:0]  Rb,
  input  logic [4:0]  Wr,
  input  logic [31:0] D,
  input  logic        We,
  output logic [31:0] Qa,
  output logic [31:0] Qb
);

  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];
  logic        wr_en;

  // Writes aimed at r0 are dropped here, so r0 never needs storage.
  assign wr_en = We && (Wr != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[Wr] = D;
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // No write bypass: a read of the address being written shows the old value
  // until the edge; forwarding belongs to the pipeline.
  assign Qa = (Ra == 5'd0) ? 32'd0 : regs_q[Ra];
  assign Qb = (Rb == 5'd0) ? 32'd0 : regs_q[Rb];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against an array model.
module tb_regfile;

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Clrn = 1'b1;
  logic [4:0]  Ra = '0, Rb = '0, Wr = '0;
  logic [31:0] D = '0;
  logic        We = 1'b0;
  logic [31:0] Qa, Qb;

  always #20 Clk = ~Clk;

  regfile dut (
    .Clk (Clk),
    .Clrn(Clrn),
    .Ra  (Ra),
    .Rb  (Rb),
    .Qa  (Qa),
    .Qb  (Qb),
    .Wr  (Wr),
    .D   (D),
    .We  (We)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A plain array of register contents; entry 0 is never written.
  logic [31:0] model [32];
  bit          model_valid = 1'b0;

  always @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model_valid = 1'b1;
    end else if (We && Wr != 5'd0) begin
      model[Wr] = D;
    end
  end

  // Compare process: outputs are checked mid-cycle on every falling edge.
  always @(negedge Clk) begin
    if (model_valid) begin
      chk("qa_model", Qa, model[Ra]);
      chk("qb_model", Qb, model[Rb]);
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 5 ns after the rising edge, clear of both clock edges.
  task automatic next_slot();
    @(posedge Clk);
    #5;
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] d,
                       input logic [4:0] ra, input logic [4:0] rb);
    We = we; Wr = wr; D = d; Ra = ra; Rb = rb;
  endtask

  // Clear pulse placed mid-cycle, well away from either edge.
  task automatic clear_pulse();
    #5;
    Clrn = 1'b0;
    #1;
    chk("clear_qa_now", Qa, 32'd0);
    chk("clear_qb_now", Qb, 32'd0);
    #3;
    Clrn = 1'b1;
  endtask

  function automatic logic [31:0] sweep_data(input int a);
    return (a * 32'h0101_0101) ^ 32'hA500_003C;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    #3;
    Clrn = 1'b0;
    drive(1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd4);
    #2;
    chk("reset_qa", Qa, 32'd0);
    chk("reset_qb", Qb, 32'd0);
    @(posedge Clk);
    #5;
    We = 1'b0;
    Clrn = 1'b1;

    // Write then read
    next_slot();
    drive(1'b1, 5'd3, 32'd666, 5'd3, 5'd0);
    @(posedge Clk); #1;
    chk("wr3_qa", Qa, 32'h0000_029A);

    // Second write, other port
    #4;
    drive(1'b1, 5'd4, 32'h0000_0666, 5'd3, 5'd4);
    @(posedge Clk); #1;
    chk("wr4_qb", Qb, 32'h0000_0666);
    chk("wr4_qa_keep", Qa, 32'h0000_029A);

    // Asynchronous clear mid-cycle
    #4;
    We = 1'b0;
    clear_pulse();
    #1;
    chk("after_clr_r3", Qa, 32'd0);
    chk("after_clr_r4", Qb, 32'd0);

    // Write enable off
    next_slot();
    drive(1'b0, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
    repeat (3) next_slot();
    chk("we_off_r5", Qa, 32'd0);

    // r0 hardwired
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    next_slot();
    We = 1'b0;
    chk("r0_qa", Qa, 32'd0);
    chk("r0_qb", Qb, 32'd0);

    // Read-during-write, no bypass
    drive(1'b1, 5'd7, 32'h1111_1111, 5'd7, 5'd0);
    next_slot();
    drive(1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd0);
    #1;
    chk("rdw_before", Qa, 32'h1111_1111);
    @(posedge Clk); #1;
    chk("rdw_after", Qa, 32'h2222_2222);
    #4;

    // Sweep all 31 addresses
    for (int a = 1; a < 32; a++) begin
      drive(1'b1, 5'(a), sweep_data(a), 5'd0, 5'd0);
      next_slot();
    end
    We = 1'b0;
    for (int a = 1; a < 32; a++) begin
      Ra = 5'(a);
      Rb = 5'(a);
      #1;
      chk("sweep_qa", Qa, sweep_data(a));
      chk("sweep_qb", Qb, sweep_data(a));
    end

    // Randomized traffic with occasional clears
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom(),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 60) == 0) clear_pulse();
      next_slot();
    end
    We = 1'b0;
    repeat (2) next_slot();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
